// File: rtl/param_stack.sv
// LIFO parameter stack with registered top-of-stack and overflow/underflow flags.
// Build option: define STACK_STICKY_ERR_EN to make the error flags sticky until reset.
module param_stack #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  localparam int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          do_push;
  logic          do_pop;
  logic          do_repl;
  logic          grow;
  logic          ovf_evt;
  logic          udf_evt;
  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] below_idx;

  assign empty = (count == '0);
  assign full  = (count == CNT_WIDTH'(DEPTH));

  always_comb begin
    do_push   = en & push & ~pop & ~full;
    do_pop    = en & pop & ~push & ~empty;
    do_repl   = en & push & pop;
    // REPLACE on an empty stack behaves exactly like a push
    grow      = do_push | (do_repl & empty);
    ovf_evt   = en & push & ~pop & full;
    udf_evt   = en & pop & ~push & empty;
    wr_en     = do_push | do_repl;
    wr_idx    = grow ? AW'(count) : AW'(count - CNT_WIDTH'(1));
    below_idx = AW'(count - CNT_WIDTH'(2));
  end

  // Storage is deliberately never cleared; only the write is blocked during reset
  always_ff @(posedge clk) begin
    if (reset && wr_en) begin
      mem[wr_idx] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
`ifdef STACK_STICKY_ERR_EN
      overflow  <= overflow | ovf_evt;
      underflow <= underflow | udf_evt;
`else
      overflow  <= ovf_evt;
      underflow <= udf_evt;
`endif
      if (grow) begin
        count    <= count + CNT_WIDTH'(1);
        data_out <= data_in;
      end else if (do_repl) begin
        data_out <= data_in;
      end else if (do_pop) begin
        count    <= count - CNT_WIDTH'(1);
        data_out <= (count == CNT_WIDTH'(1)) ? '0 : mem[below_idx];
      end
    end
  end

endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack (DEPTH=4, DATA_WIDTH=8): directed cases then random traffic.
module tb_param_stack;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int checks   = 0;
  int failures = 0;

`ifdef STACK_STICKY_ERR_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  // reference model: the stack as a queue, bottom at index 0
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  param_stack #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .en(en), .push(push), .pop(pop),
    .data_in(data_in), .data_out(data_out), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic e, input logic pu,
                            input logic po, input logic [DW-1:0] d);
    logic ov, un;
    ov = 1'b0;
    un = 1'b0;
    if (!r) begin
      q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      return;
    end
    if (e) begin
      if (pu && po) begin
        if (q.size() == 0) q.push_back(d);
        else q[q.size()-1] = d;
        m_dout = d;
      end else if (pu) begin
        if (q.size() == DEPTH) ov = 1'b1;
        else begin
          q.push_back(d);
          m_dout = d;
        end
      end else if (po) begin
        if (q.size() == 0) un = 1'b1;
        else begin
          void'(q.pop_back());
          m_dout = (q.size() == 0) ? '0 : q[q.size()-1];
        end
      end
    end
    m_ovf = STICKY ? (m_ovf | ov) : ov;
    m_udf = STICKY ? (m_udf | un) : un;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
    chk({tag, ".count"}, 32'(count), 32'(q.size()));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
  endtask

  task automatic step(input string tag, input logic r, input logic e, input logic pu,
                      input logic po, input logic [DW-1:0] d);
    @(negedge clk);
    reset = r; en = e; push = pu; pop = po; data_in = d;
    @(posedge clk);
    model_edge(r, e, pu, po, d);
    #1;
    check_model(tag);
  endtask

  initial begin
    logic r, e, pu, po;

    step("rst0", 0, 0, 0, 0, 8'h00);
    step("rst1", 0, 1, 1, 0, 8'h99);
    chk("reset.count", 32'(count), 0);
    chk("reset.empty", 32'(empty), 1);
    chk("reset.data_out", 32'(data_out), 0);

    // fill, overflow, drain
    step("fill", 1, 1, 1, 0, 8'h11);
    step("fill", 1, 1, 1, 0, 8'h12);
    step("fill", 1, 1, 1, 0, 8'h13);
    step("fill", 1, 1, 1, 0, 8'h14);
    chk("fill.data_out", 32'(data_out), 32'h14);
    chk("fill.count", 32'(count), 4);
    chk("fill.full", 32'(full), 1);
    step("ovf", 1, 1, 1, 0, 8'h55);
    chk("ovf.flag", 32'(overflow), 1);
    chk("ovf.count", 32'(count), 4);
    chk("ovf.data_out", 32'(data_out), 32'h14);
    step("ovf_after", 1, 1, 0, 0, 8'h00);
    chk("ovf_after.flag", 32'(overflow), 32'(STICKY));
    step("drain", 1, 1, 0, 1, 8'h00);
    chk("drain1", 32'(data_out), 32'h13);
    step("drain", 1, 1, 0, 1, 8'h00);
    chk("drain2", 32'(data_out), 32'h12);
    step("drain", 1, 1, 0, 1, 8'h00);
    chk("drain3", 32'(data_out), 32'h11);
    step("drain", 1, 1, 0, 1, 8'h00);
    chk("drain4.empty", 32'(empty), 1);

    // underflow then replace-on-empty
    step("rstA", 0, 0, 0, 0, 8'h00);
    step("udf", 1, 1, 0, 1, 8'h00);
    chk("udf.flag", 32'(underflow), 1);
    chk("udf.data_out", 32'(data_out), 0);
    chk("udf.count", 32'(count), 0);
    step("repl_empty", 1, 1, 1, 1, 8'h22);
    chk("repl_empty.count", 32'(count), 1);
    chk("repl_empty.data_out", 32'(data_out), 32'h22);
    chk("repl_empty.overflow", 32'(overflow), 0);

    // replace on a two-entry stack
    step("rstB", 0, 0, 0, 0, 8'h00);
    step("b", 1, 1, 1, 0, 8'h11);
    step("b", 1, 1, 1, 0, 8'h12);
    step("repl", 1, 1, 1, 1, 8'hAA);
    chk("repl.count", 32'(count), 2);
    chk("repl.data_out", 32'(data_out), 32'hAA);
    step("repl_pop", 1, 1, 0, 1, 8'h00);
    chk("repl_pop.data_out", 32'(data_out), 32'h11);

    // enable low holds everything
    step("rstC", 0, 0, 0, 0, 8'h00);
    step("c", 1, 1, 1, 0, 8'h11);
    step("c", 1, 1, 1, 0, 8'h12);
    step("hold", 1, 0, 0, 1, 8'h00);
    step("hold", 1, 0, 0, 1, 8'h00);
    chk("hold.data_out", 32'(data_out), 32'h12);
    chk("hold.count", 32'(count), 2);
    step("hold_pop", 1, 1, 0, 1, 8'h00);
    chk("hold_pop.data_out", 32'(data_out), 32'h11);

    // reset wins over a coincident push
    step("d", 1, 1, 1, 0, 8'h12);
    step("d", 1, 1, 1, 0, 8'h13);
    chk("pre_rst.count", 32'(count), 3);
    step("rst_push", 0, 1, 1, 0, 8'h33);
    chk("rst_push.count", 32'(count), 0);
    chk("rst_push.empty", 32'(empty), 1);
    chk("rst_push.data_out", 32'(data_out), 0);
    chk("rst_push.overflow", 32'(overflow), 0);
    chk("rst_push.underflow", 32'(underflow), 0);

    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) != 0);
      e  = ($urandom_range(0, 7) != 0);
      pu = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      step("rand", r, e, pu, po, 8'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bit width of each stack entry.
REQ-002 SHALL have parameter DEPTH, default 16, maximum number of entries (legal range 2..256).
REQ-003 SHALL derive localparam CNT_WIDTH = clog2(DEPTH+1), width of the occupancy count.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port en  input  1  operation enable; when low the block holds all state.
REQ-007 SHALL have port push  input  1  push request; data_in is written to the new top.
REQ-008 SHALL have port pop  input  1  pop request; the current top is removed.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  value to push.
REQ-010 SHALL have port data_out  output  DATA_WIDTH  registered top-of-stack value.
REQ-011 SHALL have port count  output  CNT_WIDTH  number of valid entries.
REQ-012 SHALL have port empty  output  1  high when count == 0.
REQ-013 SHALL have port full  output  1  high when count == DEPTH.
REQ-014 SHALL have port overflow  output  1  push rejected because the stack is full.
REQ-015 SHALL have port underflow  output  1  pop rejected because the stack is empty.

Function
REQ-016 SHALL decode each enabled edge (en=1) as: push only = PUSH, pop only = POP, both = REPLACE, neither = NOP.
REQ-017 SHALL, on PUSH when not full, store data_in at index count, increment count, and load data_out with data_in at the same edge.
REQ-018 SHALL, on POP when not empty, decrement count and load data_out with the entry at index count-2 at the same edge, or with 0 if the stack becomes empty.
REQ-019 SHALL, on REPLACE when not empty, overwrite the top entry with data_in, keep count unchanged, and load data_out with data_in; this applies when full too, without raising overflow.
REQ-020 SHALL treat REPLACE when empty as PUSH and raise no error.
REQ-021 SHALL, on PUSH when full, leave the stack, count and data_out unchanged and raise overflow.
REQ-022 SHALL, on POP when empty, leave the stack unchanged, hold data_out at 0 and raise underflow.
REQ-023 SHALL, when en=0, hold the stack, count and data_out, ignore push and pop, and raise no error.
REQ-024 SHALL drive empty and full combinationally from the registered count, with zero latency relative to count.
REQ-025 SHALL give data_out one-edge latency: the new top is visible in the cycle following the operation edge.
REQ-026 SHALL NOT reset or clear the storage array; only count, data_out and the flags carry a reset value.

Reset
REQ-027 SHALL, while reset=0 at a clk edge, set count=0, data_out=0, overflow=0 and underflow=0, so that empty=1 and full=0.
REQ-028 SHALL give reset priority over en, push and pop; an operation coinciding with reset is discarded.
REQ-029 SHALL resume normal operation at the first edge with reset=1.

Configuration
REQ-030 SHALL honour macro STACK_STICKY_ERR_EN.
REQ-031 SHALL, when STACK_STICKY_ERR_EN is defined, hold overflow and underflow high once set, until reset.
REQ-032 SHALL, when STACK_STICKY_ERR_EN is undefined, assert overflow and underflow for exactly the one cycle following the offending edge.

Verification
REQ-033 SHALL cover: DEPTH=4, DATA_WIDTH=8, push 0x11,0x12,0x13,0x14 -> data_out 0x14, count=4, full=1; then pop x3 -> data_out 0x13,0x12,0x11.
REQ-034 SHALL cover: full stack (4 entries), push 0x55 -> overflow=1, count=4, data_out=0x14; sticky build keeps overflow high, non-sticky build drops it after 1 cycle.
REQ-035 SHALL cover: empty stack, pop -> underflow=1, data_out=0, count=0; then push&pop with data_in 0x22 -> count=1, data_out=0x22, no error.
REQ-036 SHALL cover: stack holding 0x11,0x12, push&pop with 0xAA -> count=2, data_out=0xAA; then pop -> data_out=0x11.
REQ-037 SHALL cover: stack holding 0x11,0x12, en=0 with pop held for 2 cycles -> data_out=0x12, count=2; then en=1 for one pop -> data_out=0x11.
REQ-038 SHALL cover: reset=0 asserted during a push of 0x33 on a 3-entry stack -> count=0, empty=1, data_out=0, overflow=0, underflow=0.
